// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes and the slave handshake state encodings.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'b00,
        WR_PARTIAL = 2'b01,
        WR_RESP    = 2'b10
    } wr_state_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_RVALID = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port word array: byte-enabled write port, registered read port.
// A read and write to the same word on one edge returns the old contents.
module sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [STRB_WIDTH-1:0] i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Contents are never reset; only the read register is.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (i_we[i]) begin
                r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_ram.sv
// AXI-Lite slave memory: independent read and write channels in front of an sdp_ram.
// Write side state lives in the two holding flags plus bvalid; read side in rvalid.
module axil_ram
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int WORD_LSB   = $clog2(STRB_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [1:0]            o_dbg_wr_state,
    output logic                  o_dbg_rd_state
);

    localparam int IDX_W = ADDR_WIDTH - WORD_LSB;

    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic [IDX_W-1:0]      r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_WIDTH-1:0] w_wr_strb;
    logic [STRB_WIDTH-1:0] w_we;
    logic                  w_rd_en;
    wr_state_t             w_wr_state;
    rd_state_t             w_rd_state;
    logic                  w_unused;

    // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
    // Readies depend only on registered state, so a raised valid is never dropped by us
    // and the master may present valid before or after ready.
    assign s_axil_awready = !r_aw_held && !r_bvalid;
    assign s_axil_wready  = !r_w_held && !r_bvalid;
    assign s_axil_arready = !r_rvalid;

    assign w_aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_w_hs   = s_axil_wvalid && s_axil_wready;
    assign w_ar_hs  = s_axil_arvalid && s_axil_arready;
    assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_wr_idx  = r_aw_held ? r_aw_idx : s_axil_awaddr[ADDR_WIDTH-1:WORD_LSB];
    assign w_wr_data = r_w_held ? r_wdata : s_axil_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_axil_wstrb;

    // Reset on the commit edge aborts the write, so the array is gated too.
    assign w_we    = (w_commit && !rst) ? w_wr_strb : '0;
    assign w_rd_en = w_ar_hs && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= s_axil_awaddr[ADDR_WIDTH-1:WORD_LSB];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axil_wdata;
                    r_wstrb  <= s_axil_wstrb;
                end
                if (r_bvalid && s_axil_bready) begin
                    r_bvalid <= 1'b0;
                end
            end

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
            end else if (r_rvalid && s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_wr_state = WR_IDLE;
        if (r_bvalid) begin
            w_wr_state = WR_RESP;
        end else if (r_aw_held || r_w_held) begin
            w_wr_state = WR_PARTIAL;
        end
        w_rd_state = r_rvalid ? RD_RVALID : RD_IDLE;
    end

    sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(IDX_W),
        .STRB_WIDTH(STRB_WIDTH)
    ) u_ram (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (w_we),
        .i_waddr(w_wr_idx),
        .i_wdata(w_wr_data),
        .i_re   (w_rd_en),
        .i_raddr(s_axil_araddr[ADDR_WIDTH-1:WORD_LSB]),
        .o_rdata(s_axil_rdata)
    );

    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_bresp   = RESP_OKAY;
    assign s_axil_rresp   = RESP_OKAY;
    assign o_dbg_wr_state = w_wr_state;
    assign o_dbg_rd_state = w_rd_state;

    // Protection bits and byte offsets carry no meaning for this memory.
    assign w_unused = ^{s_axil_awprot, s_axil_arprot,
                        s_axil_awaddr[WORD_LSB-1:0], s_axil_araddr[WORD_LSB-1:0]};

endmodule

// File: tb/tb_axil_ram.sv
// Bench for axil_ram: scenario tasks with a read-data scoreboard and a word-level model.
module tb_axil_ram;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] s_axil_awaddr;
    logic [2:0]    s_axil_awprot;
    logic          s_axil_awvalid;
    logic          s_axil_awready;
    logic [DW-1:0] s_axil_wdata;
    logic [SW-1:0] s_axil_wstrb;
    logic          s_axil_wvalid;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;
    logic [1:0]    dbg_wr;
    logic          dbg_rd;

    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model[int];

    axil_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awprot (s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .s_axil_araddr (s_axil_araddr),
        .s_axil_arprot (s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata  (s_axil_rdata),
        .s_axil_rresp  (s_axil_rresp),
        .s_axil_rvalid (s_axil_rvalid),
        .s_axil_rready (s_axil_rready),
        .o_dbg_wr_state(dbg_wr),
        .o_dbg_rd_state(dbg_rd)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed)", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < SW; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a >> 2);
    endfunction

    // ---------------- drivers ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int aw_dly, input int w_dly,
                            output int bwait, output logic [1:0] resp);
        int cyc;
        bit aw_done, w_done, aw_fire, w_fire;
        aw_done = 0; w_done = 0; aw_fire = 0; w_fire = 0; cyc = 0;
        s_axil_bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 100) begin
            @(negedge clk);
            if (aw_fire) begin s_axil_awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin s_axil_wvalid  = 1'b0; w_done  = 1; end
            if (!aw_done && cyc >= aw_dly) begin s_axil_awvalid = 1'b1; s_axil_awaddr = a; end
            if (!w_done && cyc >= w_dly) begin
                s_axil_wvalid = 1'b1; s_axil_wdata = d; s_axil_wstrb = s;
            end
            aw_fire = s_axil_awvalid && s_axil_awready;
            w_fire  = s_axil_wvalid && s_axil_wready;
            cyc++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        bwait = 0;
        while (!s_axil_bvalid && bwait < 20) begin @(negedge clk); bwait++; end
        if (!s_axil_bvalid) bwait = -1;
        resp = s_axil_bresp;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat,
                           output logic [1:0] resp);
        int cyc;
        cyc = 0;
        @(negedge clk);
        s_axil_arvalid = 1'b1; s_axil_araddr = a; s_axil_rready = 1'b0;
        while (!s_axil_arready && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        lat = 0;
        while (!s_axil_rvalid && lat < 20) begin @(negedge clk); lat++; end
        if (!s_axil_rvalid) lat = -1;
        d = s_axil_rdata;
        resp = s_axil_rresp;
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++; if (s_axil_awready !== 1'b1) $display("FAIL rst_awready: got %b want 1", s_axil_awready); else n_pass++;
        n_total++; if (s_axil_wready !== 1'b1) $display("FAIL rst_wready: got %b want 1", s_axil_wready); else n_pass++;
        n_total++; if (s_axil_arready !== 1'b1) $display("FAIL rst_arready: got %b want 1", s_axil_arready); else n_pass++;
        n_total++; if (s_axil_bvalid !== 1'b0) $display("FAIL rst_bvalid: got %b want 0", s_axil_bvalid); else n_pass++;
        n_total++; if (s_axil_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", s_axil_rvalid); else n_pass++;
        n_total++; if (s_axil_bresp !== 2'b00) $display("FAIL rst_bresp: got %b want 00", s_axil_bresp); else n_pass++;
        n_total++; if (s_axil_rresp !== 2'b00) $display("FAIL rst_rresp: got %b want 00", s_axil_rresp); else n_pass++;
        n_total++; if (s_axil_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", s_axil_rdata); else n_pass++;
        n_total++; if (dbg_wr !== 2'b00) $display("FAIL rst_wr_state: got %0d want 0", dbg_wr); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simul_write();
        int bw, lat;
        logic [1:0] resp, rr;
        logic [DW-1:0] d, e;
        do_write(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, bw, resp);
        model[widx(16'h0010)] = 32'hDEADBEEF;
        n_total++; if (bw !== 0) $display("FAIL simul_b_latency: got %0d want 0", bw); else n_pass++;
        n_total++; if (resp !== 2'b00) $display("FAIL simul_bresp: got %b want 00", resp); else n_pass++;
        exp_q.push_back(model[widx(16'h0010)]);
        do_read(16'h0010, d, lat, rr);
        e = exp_q.pop_front();
        n_total++; if (d !== e) $display("FAIL simul_rdata: got %h want %h", d, e); else n_pass++;
        n_total++; if (lat !== 0) $display("FAIL simul_r_latency: got %0d want 0", lat); else n_pass++;
        n_total++; if (rr !== 2'b00) $display("FAIL simul_rresp: got %b want 00", rr); else n_pass++;
    endtask

    task automatic test_w_before_aw();
        int lat;
        logic [1:0] rr;
        logic [DW-1:0] d, e;
        @(negedge clk);
        s_axil_wvalid = 1'b1; s_axil_wdata = 32'h5A5AC3C3; s_axil_wstrb = 4'hF; s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_wvalid = 1'b0;
        n_total++; if (s_axil_wready !== 1'b0) $display("FAIL wfirst_wready: got %b want 0", s_axil_wready); else n_pass++;
        n_total++; if (dbg_wr !== 2'b01) $display("FAIL wfirst_state: got %0d want 1", dbg_wr); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_total++; if (s_axil_bvalid !== 1'b0) $display("FAIL wfirst_early_bvalid: got %b want 0", s_axil_bvalid); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (s_axil_awready !== 1'b1) $display("FAIL wfirst_awready: got %b want 1", s_axil_awready); else n_pass++;
        n_total++; if (s_axil_bvalid !== 1'b0) $display("FAIL wfirst_pre_aw_bvalid: got %b want 0", s_axil_bvalid); else n_pass++;
        s_axil_awvalid = 1'b1; s_axil_awaddr = 16'h0024;
        @(negedge clk);
        s_axil_awvalid = 1'b0;
        n_total++; if (s_axil_bvalid !== 1'b1) $display("FAIL wfirst_bvalid: got %b want 1", s_axil_bvalid); else n_pass++;
        @(negedge clk);
        n_total++; if (s_axil_bvalid !== 1'b0) $display("FAIL wfirst_bclear: got %b want 0", s_axil_bvalid); else n_pass++;
        model[widx(16'h0024)] = 32'h5A5AC3C3;
        exp_q.push_back(model[widx(16'h0024)]);
        do_read(16'h0024, d, lat, rr);
        e = exp_q.pop_front();
        n_total++; if (d !== e) $display("FAIL wfirst_rdata: got %h want %h", d, e); else n_pass++;
    endtask

    task automatic test_strobes();
        int bw, lat;
        logic [1:0] resp, rr;
        logic [DW-1:0] d, e;
        do_write(16'h0030, 32'h11223344, 4'hF, 0, 0, bw, resp);
        model[widx(16'h0030)] = 32'h11223344;
        do_write(16'h0030, 32'hAABBCCDD, 4'b0101, 1, 0, bw, resp);
        model[widx(16'h0030)] = merge(model[widx(16'h0030)], 32'hAABBCCDD, 4'b0101);
        exp_q.push_back(model[widx(16'h0030)]);
        do_read(16'h0030, d, lat, rr);
        e = exp_q.pop_front();
        n_total++; if (d !== 32'h11BB33DD || d !== e) $display("FAIL strb_rdata: got %h want %h", d, e); else n_pass++;
        exp_q.push_back(model[widx(16'h0033)]);
        do_read(16'h0033, d, lat, rr);
        e = exp_q.pop_front();
        n_total++; if (d !== e) $display("FAIL strb_unaligned_rdata: got %h want %h", d, e); else n_pass++;
        do_write(16'h0030, 32'hFFFFFFFF, 4'h0, 0, 0, bw, resp);
        n_total++; if (bw !== 0) $display("FAIL strb0_b_latency: got %0d want 0", bw); else n_pass++;
        n_total++; if (resp !== 2'b00) $display("FAIL strb0_bresp: got %b want 00", resp); else n_pass++;
        exp_q.push_back(model[widx(16'h0030)]);
        do_read(16'h0030, d, lat, rr);
        e = exp_q.pop_front();
        n_total++; if (d !== e) $display("FAIL strb0_rdata: got %h want %h", d, e); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e;
        @(negedge clk);
        s_axil_awvalid = 1'b1; s_axil_awaddr = 16'h0050;
        s_axil_wvalid = 1'b1; s_axil_wdata = 32'h0F0F1234; s_axil_wstrb = 4'hF; s_axil_bready = 1'b0;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        model[widx(16'h0050)] = 32'h0F0F1234;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (s_axil_bvalid !== 1'b1) $display("FAIL bp_bvalid: cycle %0d got %b want 1", i, s_axil_bvalid); else n_pass++;
            n_total++; if (s_axil_awready !== 1'b0) $display("FAIL bp_awready: cycle %0d got %b want 0", i, s_axil_awready); else n_pass++;
            n_total++; if (s_axil_wready !== 1'b0) $display("FAIL bp_wready: cycle %0d got %b want 0", i, s_axil_wready); else n_pass++;
            @(negedge clk);
        end
        s_axil_bready = 1'b1;
        @(negedge clk);
        n_total++; if (s_axil_bvalid !== 1'b0) $display("FAIL bp_bclear: got %b want 0", s_axil_bvalid); else n_pass++;
        n_total++; if (s_axil_awready !== 1'b1) $display("FAIL bp_awready_back: got %b want 1", s_axil_awready); else n_pass++;

        exp_q.push_back(model[widx(16'h0050)]);
        s_axil_arvalid = 1'b1; s_axil_araddr = 16'h0050; s_axil_rready = 1'b0;
        @(negedge clk);
        // Keep a second request waiting: it must not be taken while rvalid stalls.
        s_axil_araddr = 16'h0010;
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_total++; if (s_axil_rvalid !== 1'b1) $display("FAIL bp_rvalid: cycle %0d got %b want 1", i, s_axil_rvalid); else n_pass++;
            n_total++; if (s_axil_rdata !== e) $display("FAIL bp_rdata: cycle %0d got %h want %h", i, s_axil_rdata, e); else n_pass++;
            n_total++; if (s_axil_arready !== 1'b0) $display("FAIL bp_arready: cycle %0d got %b want 0", i, s_axil_arready); else n_pass++;
            @(negedge clk);
        end
        s_axil_rready = 1'b1;
        @(negedge clk);
        n_total++; if (s_axil_rvalid !== 1'b0) $display("FAIL bp_rclear: got %b want 0", s_axil_rvalid); else n_pass++;
        n_total++; if (s_axil_arready !== 1'b1) $display("FAIL bp_arready_back: got %b want 1", s_axil_arready); else n_pass++;
        exp_q.push_back(model[widx(16'h0010)]);
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        e = exp_q.pop_front();
        n_total++; if (s_axil_rvalid !== 1'b1) $display("FAIL bp_second_rvalid: got %b want 1", s_axil_rvalid); else n_pass++;
        n_total++; if (s_axil_rdata !== e) $display("FAIL bp_second_rdata: got %h want %h", s_axil_rdata, e); else n_pass++;
        @(negedge clk);
        s_axil_rready = 1'b0;
    endtask

    task automatic test_same_edge();
        int bw, lat;
        logic [1:0] resp, rr;
        logic [DW-1:0] d, e;
        do_write(16'h0020, 32'h00000001, 4'hF, 0, 0, bw, resp);
        model[widx(16'h0020)] = 32'h00000001;
        exp_q.push_back(model[widx(16'h0020)]);
        @(negedge clk);
        s_axil_awvalid = 1'b1; s_axil_awaddr = 16'h0020;
        s_axil_wvalid = 1'b1; s_axil_wdata = 32'h00000002; s_axil_wstrb = 4'hF; s_axil_bready = 1'b1;
        s_axil_arvalid = 1'b1; s_axil_araddr = 16'h0020; s_axil_rready = 1'b0;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        model[widx(16'h0020)] = 32'h00000002;
        e = exp_q.pop_front();
        n_total++; if (s_axil_bvalid !== 1'b1) $display("FAIL same_bvalid: got %b want 1", s_axil_bvalid); else n_pass++;
        n_total++; if (s_axil_rvalid !== 1'b1) $display("FAIL same_rvalid: got %b want 1", s_axil_rvalid); else n_pass++;
        n_total++; if (s_axil_rdata !== e) $display("FAIL same_old_rdata: got %h want %h", s_axil_rdata, e); else n_pass++;
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
        exp_q.push_back(model[widx(16'h0020)]);
        do_read(16'h0020, d, lat, rr);
        e = exp_q.pop_front();
        n_total++; if (d !== e) $display("FAIL same_new_rdata: got %h want %h", d, e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bw, lat;
        logic [1:0] resp, rr;
        logic [DW-1:0] d, e;
        do_write(16'h0040, 32'hCAFEF00D, 4'hF, 0, 0, bw, resp);
        model[widx(16'h0040)] = 32'hCAFEF00D;
        @(negedge clk);
        s_axil_awvalid = 1'b1; s_axil_awaddr = 16'h0040;
        s_axil_arvalid = 1'b1; s_axil_araddr = 16'h0040; s_axil_rready = 1'b0;
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_arvalid = 1'b0;
        n_total++; if (s_axil_awready !== 1'b0) $display("FAIL rmid_aw_held: got %b want 0", s_axil_awready); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (s_axil_awready !== 1'b1) $display("FAIL rmid_awready: got %b want 1", s_axil_awready); else n_pass++;
        n_total++; if (s_axil_wready !== 1'b1) $display("FAIL rmid_wready: got %b want 1", s_axil_wready); else n_pass++;
        n_total++; if (s_axil_arready !== 1'b1) $display("FAIL rmid_arready: got %b want 1", s_axil_arready); else n_pass++;
        n_total++; if (s_axil_bvalid !== 1'b0) $display("FAIL rmid_bvalid: got %b want 0", s_axil_bvalid); else n_pass++;
        n_total++; if (s_axil_rvalid !== 1'b0) $display("FAIL rmid_rvalid: got %b want 0", s_axil_rvalid); else n_pass++;
        n_total++; if (s_axil_rdata !== 32'h0) $display("FAIL rmid_rdata: got %h want 0", s_axil_rdata); else n_pass++;
        n_total++; if (dbg_wr !== 2'b00) $display("FAIL rmid_wr_state: got %0d want 0", dbg_wr); else n_pass++;
        exp_q.push_back(model[widx(16'h0040)]);
        do_read(16'h0040, d, lat, rr);
        e = exp_q.pop_front();
        n_total++; if (d !== e) $display("FAIL rmid_array_kept: got %h want %h", d, e); else n_pass++;
        do_write(16'h0040, 32'h600DF00D, 4'hF, 0, 0, bw, resp);
        model[widx(16'h0040)] = 32'h600DF00D;
        n_total++; if (bw !== 0) $display("FAIL rmid_fresh_b_latency: got %0d want 0", bw); else n_pass++;
        exp_q.push_back(model[widx(16'h0040)]);
        do_read(16'h0040, d, lat, rr);
        e = exp_q.pop_front();
        n_total++; if (d !== e) $display("FAIL rmid_fresh_rdata: got %h want %h", d, e); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bw, lat;
        logic [1:0] resp, rr;
        logic [DW-1:0] d, e, v;
        logic [SW-1:0] s;
        logic [AW-1:0] a;
        for (int i = 0; i < 16; i++) begin
            a = AW'(16'h0100 + i * 4);
            v = $urandom;
            do_write(a, v, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), bw, resp);
            model[widx(a)] = v;
            n_total++; if (bw !== 0) $display("FAIL b2b_fill_b_latency: addr %h got %0d want 0", a, bw); else n_pass++;
        end
        for (int i = 0; i < 12; i++) begin
            a = AW'(16'h0100 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            v = $urandom;
            s = SW'($urandom_range(0, 15));
            do_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), bw, resp);
            model[widx(a)] = merge(model[widx(a)], v, s);
            n_total++; if (resp !== 2'b00) $display("FAIL b2b_bresp: addr %h got %b want 00", a, resp); else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            a = AW'(16'h0100 + i * 4 + $urandom_range(0, 3));
            exp_q.push_back(model[widx(a)]);
            do_read(a, d, lat, rr);
            e = exp_q.pop_front();
            n_total++; if (d !== e) $display("FAIL b2b_rdata: addr %h got %h want %h", a, d, e); else n_pass++;
        end
    endtask

    initial begin
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
        test_reset();
        test_simul_write();
        test_w_before_aw();
        test_strobes();
        test_backpressure();
        test_same_edge();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axil_ram.md
# axil_ram

AXI-Lite slave memory that terminates the AXI-Lite bus driven by the core's AXI-Lite master. It serves single-beat reads and byte-strobed writes from an on-chip word array. Read and write channels are independent. It is the default data/instruction memory target behind the master, or behind an address decoder when one is present.

## Interface

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 16, byte-address width used by the array. Upper address bits beyond ADDR_WIDTH are ignored.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- WORD_LSB, $clog2(STRB_WIDTH), number of byte-offset bits dropped to form the word index.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1 / s_axil_awready  out  1
- s_axil_wdata  in  DATA_WIDTH / s_axil_wstrb  in  STRB_WIDTH
- s_axil_wvalid  in  1 / s_axil_wready  out  1
- s_axil_bresp  out  2  always OKAY (2'b00).
- s_axil_bvalid  out  1 / s_axil_bready  in  1
- s_axil_araddr  in  ADDR_WIDTH / s_axil_arprot  in  3 (ignored)
- s_axil_arvalid  in  1 / s_axil_arready  out  1
- s_axil_rdata  out  DATA_WIDTH / s_axil_rresp  out  2 (always OKAY)
- s_axil_rvalid  out  1 / s_axil_rready  in  1

## Operation

- Array: 2^(ADDR_WIDTH-WORD_LSB) words × DATA_WIDTH. Word index = addr[ADDR_WIDTH-1:WORD_LSB]; the low WORD_LSB bits are ignored (no unaligned support).
- Reset clears control state only. Array contents are not reset and are undefined at power-up.

Write path:
- Holding flags aw_held and w_held latch AW and W independently, in any order.
- awready = !aw_held && !bvalid; wready = !w_held && !bvalid. Both are combinational from registers only, never from valids.
- Commit cycle: the edge where both halves become available. Available means handshaken this cycle or already held.
- At commit: write bytes where wstrb[i]=1; leave other bytes unchanged. Clear both flags, set bvalid.
- bvalid holds until bvalid && bready, then clears. No new AW/W is accepted while bvalid=1.
- wstrb=0 is a legal no-op write that still produces a response.

Read path:
- arready = !rvalid.
- On arvalid && arready: rdata <= array[index] and rvalid <= 1 on the same edge.
- rdata and rvalid hold stable until rready, then rvalid clears. arready is high again the following cycle.
- A read and a write that commit on the same edge to the same word return the OLD data (read-before-write).

## Timing

- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, aw_held=0, w_held=0.
- Write latency: bvalid rises the cycle after the final AW/W handshake (1 cycle when both are presented together). Max throughput is one write per 2 cycles with bready tied high.
- Read latency: rvalid rises the cycle after the AR handshake. Max throughput is one read per 2 cycles.
- rst asserted mid-transaction:
  - Outputs return to reset values on that edge and held halves are discarded.
  - An in-flight (uncommitted) write does not modify the array.
  - A write already committed stays in the array.
- Valid-before-ready and ready-before-valid are both legal inputs. The block never drops a valid it has raised.

## Structure

- Shared package (axil_pkg): AXI response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11. The axil_master and future decoders use the same package.
- Sub-module sdp_ram: simple dual-port array.
  - One write port with per-byte enables.
  - One registered read port, read-before-write.
- axil_ram holds the handshake FSM logic:
  - Write side: IDLE/PARTIAL/RESP, encoded by flags plus bvalid.
  - Read side: IDLE/RVALID.

## Test plan

- Simultaneous AW+W: addr 0x0010, data 0xDEADBEEF, strb 0xF, bready=1 → bvalid one cycle later, bresp=0. Read of 0x0010 then returns 0xDEADBEEF with rvalid one cycle after the AR handshake.
- W three cycles before AW: wready drops after the W handshake; bvalid rises only the cycle after the AW handshake, with correct data written.
- Byte strobes: write 0x11223344, then 0xAABBCCDD with strb 0b0101 to the same address → read returns 0x11BB33DD.
- Backpressure: bready=0 for 5 cycles → bvalid held, awready=wready=0 throughout. Likewise rready=0 → rdata stable, arready=0.
- Same-edge read and write to word 0x20 (old 0x1, new 0x2) → read returns 0x1; a subsequent read returns 0x2.
- rst pulsed after the AW handshake but before W → all outputs at reset values. The array word is unchanged, and a fresh write completes normally.
